// File: rtl/cpu_controller_if.sv
// Control bundle between cpu_controller and the decoder/datapath/memory side.
// master = controller (consumes opcode/op, drives every control strobe); slave = the rest of the CPU.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       write;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       addr_sel;
  logic       load_addr;
  logic [1:0] mem_cmd;
  logic       halted;

  modport master (
    input  opcode, op,
    output nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
  );

  modport slave (
    output opcode, op,
    input  nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted
  );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle Moore control FSM for the 16-bit CPU: fetch, PC update, operand read, execute, write-back.
// Define CPU_MEM_INSTR_EN to add the LDR (011_00) / STR (100_00) memory instructions.
module cpu_controller (
  input  logic              clk,
  input  logic              rst_n,
  cpu_controller_if.master  bus
);

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPD,
    S_DEC,
    S_WIMM,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WREG,
`ifdef CPU_MEM_INSTR_EN
    S_ADDR,
    S_LADR,
    S_LMEM,
    S_LWB,
    S_STGD,
    S_STPS,
    S_STM,
`endif
    S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [4:0] w_enc;

  logic [2:0] w_nsel;
  logic [1:0] w_vsel;
  logic       w_loada;
  logic       w_loadb;
  logic       w_loadc;
  logic       w_loads;
  logic       w_asel;
  logic       w_bsel;
  logic       w_write;
  logic       w_load_ir;
  logic       w_load_pc;
  logic       w_reset_pc;
  logic       w_addr_sel;
  logic       w_load_addr;
  logic [1:0] w_mem_cmd;
  logic       w_halted;

  assign w_enc = {bus.opcode, bus.op};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_nsel      = 3'b000;
    w_vsel      = 2'b00;
    w_loada     = 1'b0;
    w_loadb     = 1'b0;
    w_loadc     = 1'b0;
    w_loads     = 1'b0;
    w_asel      = 1'b0;
    w_bsel      = 1'b0;
    w_write     = 1'b0;
    w_load_ir   = 1'b0;
    w_load_pc   = 1'b0;
    w_reset_pc  = 1'b0;
    w_addr_sel  = 1'b0;
    w_load_addr = 1'b0;
    w_mem_cmd   = 2'b00;
    w_halted    = 1'b0;

    case (r_state)
      S_RST: begin
        w_reset_pc = 1'b1;
        w_load_pc  = 1'b1;
        w_next     = S_IF1;
      end
      S_IF1: begin
        w_addr_sel = 1'b1;
        w_mem_cmd  = 2'b01;
        w_next     = S_IF2;
      end
      S_IF2: begin
        w_addr_sel = 1'b1;
        w_mem_cmd  = 2'b01;
        w_load_ir  = 1'b1;
        w_next     = S_UPD;
      end
      S_UPD: begin
        w_load_pc = 1'b1;
        w_next    = S_DEC;
      end
      S_DEC: begin
        // Unknown encodings park the CPU in HALT rather than guessing.
        case (w_enc)
          5'b11010:                   w_next = S_WIMM;
          5'b11000, 5'b10111:         w_next = S_GETB;
          5'b10100, 5'b10101, 5'b10110: w_next = S_GETA;
`ifdef CPU_MEM_INSTR_EN
          5'b01100, 5'b10000:         w_next = S_GETA;
`endif
          default:                    w_next = S_HALT;
        endcase
      end
      S_WIMM: begin
        w_nsel  = 3'b001;
        w_vsel  = 2'b10;
        w_write = 1'b1;
        w_next  = S_IF1;
      end
      S_GETA: begin
        w_nsel  = 3'b001;
        w_loada = 1'b1;
        w_next  = S_GETB;
`ifdef CPU_MEM_INSTR_EN
        if (w_enc == 5'b01100 || w_enc == 5'b10000) begin
          w_next = S_ADDR;
        end
`endif
      end
      S_GETB: begin
        w_nsel  = 3'b100;
        w_loadb = 1'b1;
        w_next  = S_EXEC;
      end
      S_EXEC: begin
        // opcode/op are held by the IR until the next IF2, so EXEC can qualify on them.
        w_next = S_WREG;
        case (w_enc)
          5'b11000, 5'b10111: begin
            w_asel  = 1'b1;
            w_loadc = 1'b1;
          end
          5'b10100, 5'b10110: begin
            w_loadc = 1'b1;
          end
          5'b10101: begin
            w_loads = 1'b1;
            w_next  = S_IF1;
          end
          default: ;
        endcase
      end
      S_WREG: begin
        w_nsel  = 3'b010;
        w_write = 1'b1;
        w_next  = S_IF1;
      end
`ifdef CPU_MEM_INSTR_EN
      S_ADDR: begin
        w_bsel  = 1'b1;
        w_loadc = 1'b1;
        w_next  = S_LADR;
      end
      S_LADR: begin
        w_load_addr = 1'b1;
        w_next      = (w_enc == 5'b01100) ? S_LMEM : S_STGD;
      end
      S_LMEM: begin
        w_mem_cmd = 2'b01;
        w_next    = S_LWB;
      end
      S_LWB: begin
        w_mem_cmd = 2'b01;
        w_nsel    = 3'b010;
        w_vsel    = 2'b01;
        w_write   = 1'b1;
        w_next    = S_IF1;
      end
      S_STGD: begin
        w_nsel  = 3'b010;
        w_loadb = 1'b1;
        w_next  = S_STPS;
      end
      S_STPS: begin
        w_asel  = 1'b1;
        w_loadc = 1'b1;
        w_next  = S_STM;
      end
      S_STM: begin
        w_mem_cmd = 2'b10;
        w_next    = S_IF1;
      end
`endif
      S_HALT: begin
        w_halted = 1'b1;
        w_next   = S_HALT;
      end
      default: w_next = S_RST;
    endcase
  end

  // Held reset blanks every strobe, including the RST-state PC strobes.
  assign bus.nsel      = rst_n ? w_nsel      : 3'b000;
  assign bus.vsel      = rst_n ? w_vsel      : 2'b00;
  assign bus.loada     = rst_n & w_loada;
  assign bus.loadb     = rst_n & w_loadb;
  assign bus.loadc     = rst_n & w_loadc;
  assign bus.loads     = rst_n & w_loads;
  assign bus.asel      = rst_n & w_asel;
  assign bus.bsel      = rst_n & w_bsel;
  assign bus.write     = rst_n & w_write;
  assign bus.load_ir   = rst_n & w_load_ir;
  assign bus.load_pc   = rst_n & w_load_pc;
  assign bus.reset_pc  = rst_n & w_reset_pc;
  assign bus.addr_sel  = rst_n & w_addr_sel;
  assign bus.load_addr = rst_n & w_load_addr;
  assign bus.mem_cmd   = rst_n ? w_mem_cmd   : 2'b00;
  assign bus.halted    = rst_n & w_halted;

endmodule
